// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: ALU control encodings used by the ALU control decoder
// and the execute stage.
package legv8_pkg;

  typedef enum logic [3:0] {
    ALU_AND    = 4'b0000,
    ALU_OR     = 4'b0001,
    ALU_ADD    = 4'b0010,
    ALU_SUB    = 4'b0110,
    ALU_PASS_B = 4'b0111
  } alu_op_t;

endpackage

// File: rtl/alu.sv
// Combinational LEGv8 ALU: AND/OR/ADD/SUB/PASS_B, modulo 2^N, with zero flag.
module alu
  import legv8_pkg::*;
#(
  parameter int unsigned N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   alucontrol,
  output logic [N-1:0] result,
  output logic         zero
);

  always_comb begin
    result = '0;
    case (alucontrol)
      ALU_AND:    result = a & b;
      ALU_OR:     result = a | b;
      ALU_ADD:    result = a + b;
      ALU_SUB:    result = a - b;
      ALU_PASS_B: result = b;
      // Undefined codes yield 0 so a stray decode reads as "zero".
      default:    result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// LEGv8 execute stage: operand mux, ALU, branch-target adder and EX/MEM register
// with hazard-unit stall/flush control.
module execute_stage
  import legv8_pkg::*;
#(
  parameter int unsigned N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic         stall,
  input  logic         flush,
  input  logic [3:0]   alucontrol,
  input  logic         alusrc,
  input  logic [N-1:0] readdata1,
  input  logic [N-1:0] readdata2,
  input  logic [N-1:0] signimm,
  input  logic [N-1:0] pc_id,
  input  logic [4:0]   rd_id,
  input  logic         regwrite_id,
  input  logic         memread_id,
  input  logic         memwrite_id,
  input  logic         memtoreg_id,
  input  logic         branch_id,
  output logic         ex_valid,
  output logic [N-1:0] ex_aluresult,
  output logic         ex_zero,
  output logic [N-1:0] ex_writedata,
  output logic [N-1:0] ex_branchtarget,
  output logic [4:0]   ex_rd,
  output logic         ex_regwrite,
  output logic         ex_memread,
  output logic         ex_memwrite,
  output logic         ex_memtoreg,
  output logic         ex_branch
);

  logic [N-1:0] opb;
  logic [N-1:0] alu_result;
  logic         alu_zero;
  logic [N-1:0] branch_target;
  logic         load;
  logic         keep_ctrl;

  assign opb = alusrc ? signimm : readdata2;

  alu #(
    .N(N)
  ) u_alu (
    .a         (readdata1),
    .b         (opb),
    .alucontrol(alucontrol),
    .result    (alu_result),
    .zero      (alu_zero)
  );

  // Word offset to byte offset; bits shifted out the top are dropped.
  assign branch_target = pc_id + {signimm[N-3:0], 2'b00};

  // Flush overrides stall; control bits survive only for a real, unflushed instruction.
  assign load      = flush | ~stall;
  assign keep_ctrl = in_valid & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid        <= 1'b0;
      ex_aluresult    <= '0;
      ex_zero         <= 1'b0;
      ex_writedata    <= '0;
      ex_branchtarget <= '0;
      ex_rd           <= '0;
      ex_regwrite     <= 1'b0;
      ex_memread      <= 1'b0;
      ex_memwrite     <= 1'b0;
      ex_memtoreg     <= 1'b0;
      ex_branch       <= 1'b0;
    end else if (load) begin
      ex_valid        <= keep_ctrl;
      ex_aluresult    <= alu_result;
      ex_zero         <= alu_zero;
      ex_writedata    <= readdata2;
      ex_branchtarget <= branch_target;
      ex_rd           <= rd_id;
      ex_regwrite     <= keep_ctrl & regwrite_id;
      ex_memread      <= keep_ctrl & memread_id;
      ex_memwrite     <= keep_ctrl & memwrite_id;
      ex_memtoreg     <= keep_ctrl & memtoreg_id;
      ex_branch       <= keep_ctrl & branch_id;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: the driver queues hand-computed EX/MEM contents
// for each edge and a monitor pops and compares them just after the edge.
module tb_execute_stage;

  localparam int unsigned N = 64;

  typedef struct packed {
    logic          valid;
    logic [63:0]   res;
    logic          zero;
    logic [63:0]   wd;
    logic [63:0]   bt;
    logic [4:0]    rd;
    logic [4:0]    ctrl; // {regwrite, memread, memwrite, memtoreg, branch}
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, stall, flush, alusrc;
  logic [3:0]   alucontrol;
  logic [N-1:0] readdata1, readdata2, signimm, pc_id;
  logic [4:0]   rd_id;
  logic         regwrite_id, memread_id, memwrite_id, memtoreg_id, branch_id;
  logic         ex_valid, ex_zero;
  logic [N-1:0] ex_aluresult, ex_writedata, ex_branchtarget;
  logic [4:0]   ex_rd;
  logic         ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch;

  exp_t  sb_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;

  execute_stage #(.N(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .stall          (stall),
    .flush          (flush),
    .alucontrol     (alucontrol),
    .alusrc         (alusrc),
    .readdata1      (readdata1),
    .readdata2      (readdata2),
    .signimm        (signimm),
    .pc_id          (pc_id),
    .rd_id          (rd_id),
    .regwrite_id    (regwrite_id),
    .memread_id     (memread_id),
    .memwrite_id    (memwrite_id),
    .memtoreg_id    (memtoreg_id),
    .branch_id      (branch_id),
    .ex_valid       (ex_valid),
    .ex_aluresult   (ex_aluresult),
    .ex_zero        (ex_zero),
    .ex_writedata   (ex_writedata),
    .ex_branchtarget(ex_branchtarget),
    .ex_rd          (ex_rd),
    .ex_regwrite    (ex_regwrite),
    .ex_memread     (ex_memread),
    .ex_memwrite    (ex_memwrite),
    .ex_memtoreg    (ex_memtoreg),
    .ex_branch      (ex_branch)
  );

  always #5 clk = ~clk;

  function automatic exp_t snap();
    exp_t s;
    s.valid = ex_valid;
    s.res   = ex_aluresult;
    s.zero  = ex_zero;
    s.wd    = ex_writedata;
    s.bt    = ex_branchtarget;
    s.rd    = ex_rd;
    s.ctrl  = {ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch};
    return s;
  endfunction

  function automatic exp_t mk(logic v, logic [63:0] res, logic z, logic [63:0] wd,
                              logic [63:0] bt, logic [4:0] rd, logic [4:0] ctrl);
    exp_t e;
    e.valid = v; e.res = res; e.zero = z; e.wd = wd; e.bt = bt; e.rd = rd; e.ctrl = ctrl;
    return e;
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got v=%b res=%h z=%b wd=%h bt=%h rd=%0d ctrl=%b",
               name, act.valid, act.res, act.zero, act.wd, act.bt, act.rd, act.ctrl);
      $display("     %s: need v=%b res=%h z=%b wd=%h bt=%h rd=%0d ctrl=%b",
               name, exp.valid, exp.res, exp.zero, exp.wd, exp.bt, exp.rd, exp.ctrl);
    end
  endtask

  task automatic set_in(input logic [3:0] op, input logic src, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] imm, input logic [63:0] pc,
                        input logic [4:0] rd, input logic [4:0] ctrl, input logic v,
                        input logic st, input logic fl);
    alucontrol = op; alusrc = src; readdata1 = a; readdata2 = b; signimm = imm; pc_id = pc;
    rd_id = rd; {regwrite_id, memread_id, memwrite_id, memtoreg_id, branch_id} = ctrl;
    in_valid = v; stall = st; flush = fl;
  endtask

  // Queue the expectation for the coming edge, then move past the monitor's sample.
  task automatic go(input string name, input exp_t e);
    sb_q.push_back(e);
    name_q.push_back(name);
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    string n;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n = name_q.pop_front();
        check(n, snap(), e);
      end
    end
  end

  initial begin : driver
    reset = 1'b1;
    set_in(4'b0000, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0, 5'd0, 5'b00000, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    check("reset_state", snap(), '0);
    reset = 1'b0;

    set_in(4'b0010, 1'b0, 64'd5, 64'd7, 64'd1, 64'h40, 5'd3, 5'b10101, 1'b1, 1'b0, 1'b0);
    go("add", mk(1, 64'd12, 0, 64'd7, 64'h44, 5'd3, 5'b10101));
    set_in(4'b0110, 1'b0, 64'h1234, 64'h1234, 64'd0, 64'h100, 5'd7, 5'b01010, 1'b1, 1'b0,
           1'b0);
    go("sub_eq", mk(1, 64'd0, 1, 64'h1234, 64'h100, 5'd7, 5'b01010));
    set_in(4'b0110, 1'b0, 64'd0, 64'd1, 64'd0, 64'd0, 5'd1, 5'b10000, 1'b1, 1'b0, 1'b0);
    go("sub_wrap", mk(1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'd1, 64'd0, 5'd1, 5'b10000));
    set_in(4'b0111, 1'b0, 64'hDEAD, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h100, 5'd31, 5'b00001,
           1'b1, 1'b0, 1'b0);
    go("passb_cbz", mk(1, 64'd0, 1, 64'd0, 64'hF8, 5'd31, 5'b00001));
    set_in(4'b0010, 1'b1, 64'h20, 64'h99, 64'h10, 64'h200, 5'd9, 5'b10000, 1'b1, 1'b0, 1'b0);
    go("addi", mk(1, 64'h30, 0, 64'h99, 64'h240, 5'd9, 5'b10000));
    set_in(4'b1111, 1'b0, 64'd3, 64'd4, 64'd0, 64'd0, 5'd2, 5'b10000, 1'b1, 1'b0, 1'b0);
    go("unknown_op", mk(1, 64'd0, 1, 64'd4, 64'd0, 5'd2, 5'b10000));
    set_in(4'b0000, 1'b0, 64'hF0F0, 64'h0FF0, 64'd3, 64'h10, 5'd4, 5'b11000, 1'b1, 1'b0, 1'b0);
    go("and", mk(1, 64'h00F0, 0, 64'h0FF0, 64'h1C, 5'd4, 5'b11000));
    // Top bits of the offset fall off the shift.
    set_in(4'b0001, 1'b0, 64'hF0F0, 64'h0FF0, 64'h4000_0000_0000_0001, 64'd0, 5'd5, 5'b10000,
           1'b1, 1'b0, 1'b0);
    go("or_btshift", mk(1, 64'hFFF0, 0, 64'h0FF0, 64'd4, 5'd5, 5'b10000));
    set_in(4'b0111, 1'b1, 64'd0, 64'd0, 64'd2, 64'hFFFF_FFFF_FFFF_FFFC, 5'd6, 5'b00001, 1'b1,
           1'b0, 1'b0);
    go("bt_wrap", mk(1, 64'd2, 0, 64'd0, 64'd4, 5'd6, 5'b00001));
    set_in(4'b0000, 1'b0, 64'd1, 64'd1, 64'd1, 64'd4, 5'd8, 5'b11111, 1'b0, 1'b0, 1'b0);
    go("invalid_bubble", mk(0, 64'd1, 0, 64'd1, 64'd8, 5'd8, 5'b00000));

    // Load a slot, then stall for three cycles while the inputs keep changing.
    set_in(4'b0010, 1'b0, 64'd100, 64'd23, 64'd2, 64'h80, 5'd10, 5'b10100, 1'b1, 1'b0, 1'b0);
    go("pre_stall", mk(1, 64'd123, 0, 64'd23, 64'h88, 5'd10, 5'b10100));
    for (int i = 0; i < 3; i++) begin
      set_in(4'b0110, 1'b1, 64'(i), 64'(i + 50), 64'(i), 64'(i * 4), 5'(20 + i), 5'b01011,
             1'b1, 1'b1, 1'b0);
      go($sformatf("stall_hold%0d", i), mk(1, 64'd123, 0, 64'd23, 64'h88, 5'd10, 5'b10100));
    end
    set_in(4'b0110, 1'b0, 64'd9, 64'd4, 64'd0, 64'h20, 5'd11, 5'b10000, 1'b1, 1'b0, 1'b0);
    go("stall_release", mk(1, 64'd5, 0, 64'd4, 64'h20, 5'd11, 5'b10000));

    set_in(4'b0010, 1'b0, 64'd2, 64'd3, 64'd0, 64'd0, 5'd4, 5'b11111, 1'b1, 1'b1, 1'b1);
    go("stall_flush", mk(0, 64'd5, 0, 64'd3, 64'd0, 5'd4, 5'b00000));
    set_in(4'b0001, 1'b0, 64'd8, 64'd1, 64'd1, 64'd0, 5'd12, 5'b00110, 1'b1, 1'b0, 1'b1);
    go("flush", mk(0, 64'd9, 0, 64'd1, 64'd4, 5'd12, 5'b00000));

    // Valid slot, hold it with stall, then reset between edges.
    set_in(4'b0010, 1'b0, 64'd1, 64'd1, 64'd1, 64'd0, 5'd13, 5'b11111, 1'b1, 1'b0, 1'b0);
    go("pre_reset", mk(1, 64'd2, 0, 64'd1, 64'd4, 5'd13, 5'b11111));
    stall = 1'b1;
    #3 reset = 1'b1;
    #1 check("async_reset", snap(), '0);
    #1 reset = 1'b0;
    set_in(4'b0110, 1'b0, 64'd10, 64'd3, 64'd1, 64'h10, 5'd14, 5'b10000, 1'b1, 1'b0, 1'b0);
    go("post_reset", mk(1, 64'd7, 0, 64'd3, 64'h14, 5'd14, 5'b10000));

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, need 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
